// File: rtl/regfile_ctrl_pkg.sv
// Shared encodings for the register-file sequencer: FSM states, instruction
// fields, instruction classes and datapath select/ALU codes.
package regfile_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DECODE    = 3'd1,
        S_GET_A     = 3'd2,
        S_GET_B     = 3'd3,
        S_EXEC      = 3'd4,
        S_WRITE_REG = 3'd5,
        S_WRITE_IMM = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_ILLEGAL = 3'd0,
        C_MOVI    = 3'd1,
        C_MOV     = 3'd2,
        C_ALU     = 3'd3,
        C_CMP     = 3'd4,
        C_MVN     = 3'd5
    } iclass_t;

    localparam logic [2:0] OPC_MOVE = 3'b110;
    localparam logic [2:0] OPC_ALU  = 3'b101;

    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_MOV  = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MVN  = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    localparam logic [1:0] VSEL_C   = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b10;

    // For opcode 101 the op field already equals the ALU code; MOV reuses ADD.
    function automatic logic [1:0] alu_code(input iclass_t cls, input logic [1:0] op);
        return (cls == C_MOV) ? ALU_ADD : op;
    endfunction

endpackage

// File: rtl/regfile_ctrl_instr_dec.sv
// Combinational decoder from the latched instruction to its class and fields.
// CMP is only recognised when REGFILE_CTRL_CMP_EN is defined.
module regfile_ctrl_instr_dec
    import regfile_ctrl_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] ir,
    output iclass_t      cls,
    output logic [1:0]   op,
    output logic [2:0]   rn,
    output logic [2:0]   rd,
    output logic [2:0]   rm,
    output logic [1:0]   shift,
    output logic [W-1:0] sximm8
);

    logic [2:0] opcode;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign shift  = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = {{(W-8){ir[7]}}, ir[7:0]};

    always_comb begin
        cls = C_ILLEGAL;
        if (opcode == OPC_MOVE) begin
            if (op == OP_MOVI)
                cls = C_MOVI;
            else if (op == OP_MOV)
                cls = C_MOV;
        end else if (opcode == OPC_ALU) begin
            case (op)
                OP_ADD, OP_AND: cls = C_ALU;
                OP_MVN:         cls = C_MVN;
`ifdef REGFILE_CTRL_CMP_EN
                OP_CMP:         cls = C_CMP;
`endif
                default:        cls = C_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/regfile_ctrl.sv
// Multi-cycle sequencer driving the register file, ALU and shifter strobes.
// Optional CMP support is enabled by defining REGFILE_CTRL_CMP_EN.
module regfile_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] instr,
    output logic         in_ready,
    output logic [2:0]   readnum,
    output logic [2:0]   writenum,
    output logic         write,
    output logic         loada,
    output logic         loadb,
    output logic         loadc,
    output logic         loads,
    output logic         asel,
    output logic         bsel,
    output logic [1:0]   vsel,
    output logic [1:0]   aluop,
    output logic [1:0]   shift,
    output logic [W-1:0] sximm8,
    output logic         done,
    output logic         illegal
);

    state_t       state, next_state;
    logic [W-1:0] ir;
    iclass_t      cls;
    logic [1:0]   op;
    logic [2:0]   rn, rd, rm;

    regfile_ctrl_instr_dec #(.W(W)) u_dec (
        .ir     (ir),
        .cls    (cls),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .rm     (rm),
        .shift  (shift),
        .sximm8 (sximm8)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            ir    <= '0;
        end else begin
            state <= next_state;
            if (state == S_IDLE && in_valid)
                ir <= instr;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        readnum    = 3'd0;
        writenum   = 3'd0;
        write      = 1'b0;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        vsel       = VSEL_C;
        aluop      = ALU_ADD;
        done       = 1'b0;
        illegal    = 1'b0;

        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    next_state = S_DECODE;
            end
            S_DECODE: begin
                case (cls)
                    C_MOVI:        next_state = S_WRITE_IMM;
                    C_MOV, C_MVN:  next_state = S_GET_B;
                    C_ALU, C_CMP:  next_state = S_GET_A;
                    default: begin
                        illegal    = 1'b1;
                        next_state = S_IDLE;
                    end
                endcase
            end
            S_GET_A: begin
                readnum    = rn;
                loada      = 1'b1;
                next_state = S_GET_B;
            end
            S_GET_B: begin
                readnum    = rm;
                loadb      = 1'b1;
                next_state = S_EXEC;
            end
            S_EXEC: begin
                // MOV and MVN pass B through the ALU with A forced to zero.
                asel  = (cls == C_MOV) || (cls == C_MVN);
                aluop = alu_code(cls, op);
`ifdef REGFILE_CTRL_CMP_EN
                if (cls == C_CMP) begin
                    loads      = 1'b1;
                    done       = 1'b1;
                    next_state = S_IDLE;
                end else
`endif
                begin
                    loadc      = 1'b1;
                    next_state = S_WRITE_REG;
                end
            end
            S_WRITE_REG: begin
                writenum   = rd;
                vsel       = VSEL_C;
                write      = 1'b1;
                done       = 1'b1;
                next_state = S_IDLE;
            end
            S_WRITE_IMM: begin
                writenum   = rn;
                vsel       = VSEL_IMM;
                write      = 1'b1;
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl; outputs are sampled on the falling clock edge.
module tb_regfile_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] instr;
    logic        in_ready;
    logic [2:0]  readnum, writenum;
    logic        write, loada, loadb, loadc, loads, asel, bsel, done, illegal;
    logic [1:0]  vsel, aluop, shift;
    logic [15:0] sximm8;
    logic [19:0] obs;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    regfile_ctrl #(.W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .instr    (instr),
        .in_ready (in_ready),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .vsel     (vsel),
        .aluop    (aluop),
        .shift    (shift),
        .sximm8   (sximm8),
        .done     (done),
        .illegal  (illegal)
    );

    assign obs = {in_ready, readnum, writenum, write, loada, loadb, loadc, loads,
                  asel, bsel, vsel, aluop, done, illegal};

    function automatic logic [19:0] pk(input logic rdy, input logic [2:0] rdn,
                                       input logic [2:0] wrn, input logic wr,
                                       input logic la, input logic lb, input logic lc,
                                       input logic ls, input logic as, input logic bs,
                                       input logic [1:0] vs, input logic [1:0] op,
                                       input logic dn, input logic il);
        return {rdy, rdn, wrn, wr, la, lb, lc, ls, as, bs, vs, op, dn, il};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic issue(input logic [15:0] v);
        in_valid = 1'b1;
        instr    = v;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; instr = 16'h0000;
        step();
        chk("reset_strobes", obs, pk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,0));
        chk("reset_sximm8", sximm8, 16'h0000);
        chk("reset_shift", shift, 2'b00);
        rst_n = 1'b1;
        step();
        chk("idle_after_reset", obs, pk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,0));

        // MOVI R3, #-2
        issue(16'hD3FE);
        chk("movi_decode", obs, pk(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,0));
        chk("movi_sximm8", sximm8, 16'hFFFE);
        step();
        chk("movi_write_imm", obs, pk(0,0,3,1,0,0,0,0,0,0,2'b10,2'b00,1,0));
        step();
        chk("movi_idle", obs, pk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,0));

        // ADD R2, R1, R0
        issue(16'hA140);
        chk("add_decode", obs, pk(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,0));
        step();
        chk("add_get_a", obs, pk(0,1,0,0,1,0,0,0,0,0,2'b00,2'b00,0,0));
        step();
        chk("add_get_b", obs, pk(0,0,0,0,0,1,0,0,0,0,2'b00,2'b00,0,0));
        step();
        chk("add_exec", obs, pk(0,0,0,0,0,0,1,0,0,0,2'b00,2'b00,0,0));
        step();
        chk("add_write_reg", obs, pk(0,0,2,1,0,0,0,0,0,0,2'b00,2'b00,1,0));
        chk("add_sximm8", sximm8, 16'h0040);
        step();
        chk("add_idle", obs, pk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,0));

        // MVN R7, R5, shift 01
        issue(16'hB8ED);
        chk("mvn_decode", obs, pk(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,0));
        step();
        chk("mvn_get_b", obs, pk(0,5,0,0,0,1,0,0,0,0,2'b00,2'b00,0,0));
        chk("mvn_shift", shift, 2'b01);
        step();
        chk("mvn_exec", obs, pk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b11,0,0));
        step();
        chk("mvn_write_reg", obs, pk(0,0,7,1,0,0,0,0,0,0,2'b00,2'b00,1,0));
        chk("mvn_sximm8", sximm8, 16'hFFED);
        step();
        chk("mvn_idle", obs, pk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,0));

        // CMP R1, R2
        issue(16'hA902);
`ifdef REGFILE_CTRL_CMP_EN
        chk("cmp_decode", obs, pk(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,0));
        step();
        chk("cmp_get_a", obs, pk(0,1,0,0,1,0,0,0,0,0,2'b00,2'b00,0,0));
        step();
        chk("cmp_get_b", obs, pk(0,2,0,0,0,1,0,0,0,0,2'b00,2'b00,0,0));
        step();
        chk("cmp_exec", obs, pk(0,0,0,0,0,0,0,1,0,0,2'b00,2'b01,1,0));
`else
        chk("cmp_illegal", obs, pk(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,1));
`endif
        step();
        chk("cmp_idle", obs, pk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,0));

        // Illegal opcode 000 and illegal 110/01
        issue(16'h0000);
        chk("ill0_decode", obs, pk(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,1));
        step();
        chk("ill0_idle", obs, pk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,0));
        issue(16'hC8FF);
        chk("ill_mov01_decode", obs, pk(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,1));
        step();
        chk("ill_mov01_idle", obs, pk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,0));

        // Asynchronous reset during GET_B of ADD
        issue(16'hA140);
        step();
        step();
        chk("rst_pre_get_b", obs, pk(0,0,0,0,0,1,0,0,0,0,2'b00,2'b00,0,0));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_strobes", obs, pk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,0));
        chk("rst_async_sximm8", sximm8, 16'h0000);
        step();
        chk("rst_held", obs, pk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,0));
        rst_n = 1'b1;
        step();
        chk("rst_released_idle", obs, pk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,0));

        // MOVI R4, #127 after reset
        issue(16'hD47F);
        chk("movi2_sximm8", sximm8, 16'h007F);
        step();
        chk("movi2_write_imm", obs, pk(0,0,4,1,0,0,0,0,0,0,2'b10,2'b00,1,0));
        step();
        chk("movi2_idle", obs, pk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,0));

        // MOV R6, R1 with in_valid held high and instr changed while busy
        in_valid = 1'b1;
        instr    = 16'hC0C1;
        @(posedge clk);
        #1 instr = 16'hD405;
        step();
        chk("hold_decode", obs, pk(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,0));
        chk("hold_decode_sximm8", sximm8, 16'hFFC1);
        step();
        chk("hold_get_b", obs, pk(0,1,0,0,0,1,0,0,0,0,2'b00,2'b00,0,0));
        step();
        chk("hold_exec", obs, pk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,0,0));
        chk("hold_exec_sximm8", sximm8, 16'hFFC1);
        step();
        chk("hold_write_reg", obs, pk(0,0,6,1,0,0,0,0,0,0,2'b00,2'b00,1,0));
        step();
        chk("hold_idle", obs, pk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,0));
        @(posedge clk);
        #1 in_valid = 1'b0;
        step();
        chk("hold_second_decode_sximm8", sximm8, 16'h0005);
        step();
        chk("hold_second_write_imm", obs, pk(0,0,4,1,0,0,0,0,0,0,2'b10,2'b00,1,0));
        step();
        chk("hold_second_idle", obs, pk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_ctrl.md
# regfile_ctrl

Multi-cycle sequencer for the 8×16 register-file datapath. It accepts one 16-bit instruction per valid/ready handshake and decodes it. It then drives `readnum`, `writenum`, `write` and the datapath load/select strobes in a fixed state sequence, pulsing `done` on the final cycle. It sits between the instruction source and the register file, ALU and shifter, and is the only master of the register-file write port.

## Interface
- `W`, default 16: datapath and instruction width.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: the instruction on `instr` is valid.
- `instr` input, W bits:
  - `[15:13]` opcode; `[12:11]` op; `[10:8]` Rn; `[7:5]` Rd; `[4:3]` shift; `[2:0]` Rm; `[7:0]` imm8.
- `in_ready` output, 1 bit: high only in IDLE.
- `readnum` output, 3 bits: register-file read address.
- `writenum` output, 3 bits: register-file write address.
- `write` output, 1 bit: register-file write enable.
- `loada` / `loadb` / `loadc` output, 1 bit each: load strobes for the A, B and C datapath registers.
- `loads` output, 1 bit: status register load.
- `asel` output, 1 bit: 1 forces the ALU A operand to zero.
- `bsel` output, 1 bit: 1 selects `sximm8` as the B operand.
- `vsel` output, 2 bits: write-data select; 00 = C, 10 = sximm8.
- `aluop` output, 2 bits: 00 ADD, 01 SUB, 10 AND, 11 NOT-B.
- `shift` output, 2 bits: shifter control, equal to latched `instr[4:3]`.
- `sximm8` output, W bits: sign-extended latched imm8.
- `done` output, 1 bit: final cycle of an instruction.
- `illegal` output, 1 bit: one-cycle pulse when an undecodable instruction is dropped.

## Operation
- Instructions:
  - MOVI (110/10): Rn ← sximm8.
  - MOV (110/00): Rd ← sh(Rm).
  - ADD (101/00): Rd ← Rn + sh(Rm).
  - CMP (101/01): status ← Rn − sh(Rm); only with the Configuration macro.
  - AND (101/10): Rd ← Rn & sh(Rm).
  - MVN (101/11): Rd ← ~sh(Rm).
  - All other encodings are illegal.
- The instruction register latches `instr` on the rising edge where `in_valid & in_ready` is true.
- States and transitions:
  - IDLE: `in_ready`=1. Go to DECODE on handshake.
  - DECODE:
    - MOVI → WRITE_IMM.
    - MOV, MVN → GET_B.
    - ADD, AND, CMP → GET_A.
    - Illegal → IDLE, with `illegal`=1 this cycle.
  - GET_A: `readnum`=Rn, `loada`=1 → GET_B.
  - GET_B: `readnum`=Rm, `loadb`=1 → EXEC.
  - EXEC:
    - `asel`=1 for MOV/MVN, else 0. `bsel`=0.
    - `aluop`: MOV→00, ADD→00, CMP→01, AND→10, MVN→11.
    - CMP: `loads`=1, `loadc`=0, `done`=1 → IDLE.
    - All others: `loadc`=1 → WRITE_REG.
  - WRITE_REG: `writenum`=Rd, `vsel`=00, `write`=1, `done`=1 → IDLE.
  - WRITE_IMM: `writenum`=Rn, `vsel`=10, `write`=1, `done`=1 → IDLE.
- All strobes are Moore outputs decoded from the state and the latched instruction. In states that do not drive them, strobes are 0 and addresses are 0.
- `shift` and `sximm8` reflect the latched instruction in every state.
- `in_valid` is ignored outside IDLE. Upstream holds `instr` until `in_ready` is high.

## Timing
- Reset (async assert, sync release):
  - State goes to IDLE and the instruction register clears to 0.
  - Outputs: `in_ready`=1; every other output 0, including `sximm8`=0.
- Reset mid-instruction aborts it with no `write` and no `done`; a pending register write is lost.
- Latency, counted from the handshake edge to the edge that completes the write or status load:
  - MOVI: 2 cycles.
  - MOV, MVN, CMP: 4 cycles.
  - ADD, AND: 5 cycles.
- Illegal instructions take 1 cycle (DECODE) and return to IDLE.
- `done` is high for exactly one cycle. The next handshake is possible on the cycle after `done`, so there is no back-to-back overlap.
- Sign extension: `sximm8 = {{8{imm8[7]}}, imm8}`.

## Configuration
- `REGFILE_CTRL_CMP_EN`:
  - Defined: CMP is decoded as above and drives `loads`.
  - Undefined: 101/01 is illegal and takes the DECODE → IDLE path with `illegal`=1. The `loads` port remains but is tied to 0.

## Structure
- Shared package `regfile_ctrl_pkg` holds:
  - the state encoding: IDLE=0, DECODE, GET_A, GET_B, EXEC, WRITE_REG, WRITE_IMM;
  - opcode/op constants;
  - `aluop` and `vsel` encodings.
- One natural sub-module is `instr_dec`. It is a combinational decoder from the latched instruction to the class (MOVI/MOV/ALU/CMP/MVN/illegal), Rn, Rd, Rm, shift and sximm8.

## Test plan
- MOVI R3, #−2 (`instr`=16'hD3FE):
  - → `write`=1, `writenum`=3, `vsel`=10, `sximm8`=16'hFFFE two cycles after the handshake.
  - `done` is high in that same cycle.
- ADD R2, R1, R0 (`instr`=16'hA140):
  - → GET_A `readnum`=1, `loada`=1; GET_B `readnum`=0, `loadb`=1; EXEC `aluop`=00, `loadc`=1.
  - WRITE_REG `writenum`=2, `write`=1, `done`=1.
  - 5 cycles total.
- MVN R7, R5 with shift 01 (`instr`=16'hB8ED):
  - → GET_A is skipped; EXEC `asel`=1, `aluop`=11, `shift`=01.
  - Write to R7 on cycle 4.
- CMP R1, R2 (`instr`=16'hA902):
  - With the macro → `loads`=1 in EXEC, `done` on cycle 4, `write` never asserted.
  - Without the macro → `illegal` pulse on cycle 1, return to IDLE.
- Illegal opcode 000 (`instr`=16'h0000) → `illegal`=1 for one cycle, no `write`, `in_ready` high the next cycle.
- `rst_n` driven low during GET_B of ADD, held 1 cycle then released:
  - → outputs clear immediately, without waiting for a clock edge, and no `write` occurs.
  - `in_ready`=1. A following MOVI completes normally.
  - Separately, `in_valid` held high while busy → no second latch until IDLE.
